// File: rtl/maquina_lectura.sv
// Read sequencer for the multiplexed RTC bus: issues the RAM transfer command, reads the
// clock (and optionally timer) registers into shadows, then commits them to the outputs at once.
module maquina_lectura #(
  parameter bit         READ_TIMER = 1'b1,
  parameter logic [7:0] CMD_ADDR   = 8'hF0,
  parameter logic [7:0] CMD_DATA   = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       lectura,
  input  logic       DIR,
  input  logic       DAT,
  input  logic       cambio_estado,
  input  logic [7:0] dato_in,
  output logic [7:0] dir_dato,
  output logic       E_lect,
  output logic       wr_rd,
  output logic       ocupado,
  output logic       Term_Lect,
  output logic [7:0] Seg,
  output logic [7:0] Min,
  output logic [7:0] Hora,
  output logic [7:0] Dia,
  output logic [7:0] Mes,
  output logic [7:0] Ano,
  output logic [7:0] T_Seg,
  output logic [7:0] T_Min,
  output logic [7:0] T_Hora
);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    CMD     = 4'd1,
    R_SEG   = 4'd2,
    R_MIN   = 4'd3,
    R_HORA  = 4'd4,
    R_DIA   = 4'd5,
    R_MES   = 4'd6,
    R_ANO   = 4'd7,
    R_TSEG  = 4'd8,
    R_TMIN  = 4'd9,
    R_THORA = 4'd10,
    COMMIT  = 4'd11
  } state_t;

  state_t     state;
  logic [7:0] shadow [0:8];
  logic [3:0] idx;

  // Read steps are contiguous from R_SEG, so the shadow slot is a plain offset.
  assign idx     = state - R_SEG;
  assign ocupado = (state != IDLE);

  function automatic logic [7:0] step_addr(input state_t s);
    case (s)
      CMD:     return CMD_ADDR;
      R_SEG:   return 8'h21;
      R_MIN:   return 8'h22;
      R_HORA:  return 8'h23;
      R_DIA:   return 8'h24;
      R_MES:   return 8'h25;
      R_ANO:   return 8'h26;
      R_TSEG:  return 8'h41;
      R_TMIN:  return 8'h42;
      R_THORA: return 8'h43;
      default: return 8'h00;
    endcase
  endfunction

  function automatic state_t next_step(input state_t s);
    case (s)
      CMD:     return R_SEG;
      R_SEG:   return R_MIN;
      R_MIN:   return R_HORA;
      R_HORA:  return R_DIA;
      R_DIA:   return R_MES;
      R_MES:   return R_ANO;
      R_ANO:   return READ_TIMER ? R_TSEG : COMMIT;
      R_TSEG:  return R_TMIN;
      R_TMIN:  return R_THORA;
      default: return COMMIT;
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      dir_dato  <= 8'h00;
      E_lect    <= 1'b0;
      wr_rd     <= 1'b0;
      Term_Lect <= 1'b0;
      Seg       <= 8'h00;
      Min       <= 8'h00;
      Hora      <= 8'h00;
      Dia       <= 8'h00;
      Mes       <= 8'h00;
      Ano       <= 8'h00;
      T_Seg     <= 8'h00;
      T_Min     <= 8'h00;
      T_Hora    <= 8'h00;
      for (int i = 0; i < 9; i++) shadow[i] <= 8'h00;
    end else begin
      Term_Lect <= 1'b0;
      case (state)
        IDLE: begin
          if (lectura) begin
            state  <= CMD;
            E_lect <= 1'b1;
            wr_rd  <= 1'b1;
          end else begin
            E_lect <= 1'b0;
          end
        end
        CMD, R_SEG, R_MIN, R_HORA, R_DIA, R_MES, R_ANO, R_TSEG, R_TMIN, R_THORA: begin
          if (DIR) begin
            dir_dato <= step_addr(state);
          end else if (DAT) begin
            if (state == CMD) dir_dato <= CMD_DATA;
            else              shadow[idx] <= dato_in;
          end else if (cambio_estado) begin
            // Dropping E_lect for one cycle restarts the timing generator on the next step.
            E_lect <= 1'b0;
            wr_rd  <= 1'b0;
            state  <= next_step(state);
          end else begin
            E_lect <= 1'b1;
          end
        end
        COMMIT: begin
          Seg       <= shadow[0];
          Min       <= shadow[1];
          Hora      <= shadow[2];
          Dia       <= shadow[3];
          Mes       <= shadow[4];
          Ano       <= shadow[5];
          T_Seg     <= READ_TIMER ? shadow[6] : 8'h00;
          T_Min     <= READ_TIMER ? shadow[7] : 8'h00;
          T_Hora    <= READ_TIMER ? shadow[8] : 8'h00;
          Term_Lect <= 1'b1;
          E_lect    <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          state  <= IDLE;
          E_lect <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/maquina_lectura.md
Name: maquina_lectura

Overview:
- Read sequencer for the multiplexed address/data RTC bus. It is the counterpart of the existing write sequencer.
- On a read request it first writes the transfer command (address 0xF0, data 0x00), which copies clock and timer into RTC RAM. It then performs read cycles of the clock registers (0x21–0x26) and, optionally, the timer registers (0x41–0x43).
- Captured bytes go into shadow registers. They are committed to the outputs together, so the display and control logic always see a consistent time set.
- Bus cycle timing (DIR/DAT/cambio_estado strobes) comes from the shared bus timing generator.

Parameters:
- READ_TIMER, 1: 1 means read timer registers 0x41/0x42/0x43 after the year; 0 means skip them.
- CMD_ADDR, 8'hF0: address of the RAM transfer command.
- CMD_DATA, 8'h00: data byte written with the transfer command.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- lectura  in  1  read request; sampled only in IDLE
- DIR  in  1  timing-gen strobe: address phase; present address on dir_dato
- DAT  in  1  timing-gen strobe: data phase; CMD step drives data, read steps sample dato_in
- cambio_estado  in  1  timing-gen strobe: current bus cycle finished
- dato_in  in  8  byte read from RTC bus
- dir_dato  out  8  registered address/data byte driven to the bus
- E_lect  out  1  registered; requests a bus cycle from the timing generator
- wr_rd  out  1  registered; 1 for the command write step, 0 for read steps
- ocupado  out  1  high whenever the state is not IDLE
- Term_Lect  out  1  registered one-cycle pulse; outputs updated
- Seg, Min, Hora, Dia, Mes, Ano  out  8 each  committed clock values
- T_Seg, T_Min, T_Hora  out  8 each  committed timer values (hold 0 if READ_TIMER=0)

Behaviour:
- Reset (async): state IDLE. dir_dato=0, E_lect=0, wr_rd=0, Term_Lect=0. All value outputs and shadow registers are 0.
- Step sequence: IDLE, CMD(F0), R_SEG(21), R_MIN(22), R_HORA(23), R_DIA(24), R_MES(25), R_ANO(26), then [R_TSEG(41), R_TMIN(42), R_THORA(43)] if READ_TIMER, then COMMIT, then IDLE.
- IDLE:
  - If lectura=1: go to CMD next edge, with E_lect=1 and wr_rd=1.
  - Otherwise E_lect=0.
  - ocupado=0.
- Each bus step, per edge, strobes are evaluated with priority DIR > DAT > cambio_estado:
  - DIR: dir_dato <= step address; E_lect holds.
  - DAT in CMD: dir_dato <= CMD_DATA.
  - DAT in a read step: the step's shadow register <= dato_in, sampled at this edge; dir_dato is unchanged.
  - cambio_estado: E_lect <= 0 and advance to the next step. wr_rd <= 0 when leaving CMD.
  - No strobe: E_lect <= 1; stay in the step.
- E_lect is therefore low for exactly one cycle between steps. The timing generator restarts on its rising edge.
- Multiple DAT pulses in one step: the last sample wins.
- A step with no DAT before cambio_estado keeps the previous shadow value.
- COMMIT (one cycle):
  - All shadow registers copy to the outputs simultaneously.
  - Term_Lect=1 on the following cycle; E_lect=0; next state IDLE.
- Outputs change only on that COMMIT edge. They never change mid-sequence.
- lectura while ocupado: ignored, not queued. lectura held high after completion starts a new sequence from IDLE on the next cycle.
- Reset mid-sequence: immediate abort to reset values. Partially read data is discarded and not committed.
- Illegal state encoding: return to IDLE with E_lect=0.
- Latency: the bus determines it. Term_Lect comes 2 cycles after the final cambio_estado (COMMIT cycle, then pulse).
- No BCD conversion or range checking; bytes pass through as read.

Test Plan:
- Reset with all inputs at 0: all outputs 0 and ocupado=0. Pulse lectura: next cycle E_lect=1, wr_rd=1, ocupado=1.
- CMD step, DIR pulse then DAT pulse then cambio_estado: dir_dato=0xF0 after DIR, 0x00 after DAT. After cambio_estado, E_lect is 0 for 1 cycle, then 1 again with wr_rd=0.
- Full read, READ_TIMER=1:
  - dato_in on each DAT = 0x45,0x30,0x12,0x15,0x09,0x16,0x05,0x10,0x00.
  - dir_dato on each DIR = 0x21..0x26, 0x41..0x43.
  - After the last cambio_estado: Seg=0x45, Min=0x30, Hora=0x12, Dia=0x15, Mes=0x09, Ano=0x16, T_Seg=0x05, T_Min=0x10, T_Hora=0x00, then a single Term_Lect pulse.
  - Outputs stay at their old values until COMMIT.
- READ_TIMER=0: after R_ANO cambio_estado the block goes straight to COMMIT; no 0x41 address is driven; T_* stay 0.
- lectura pulsed during R_MIN: no effect on sequence or step count. Exactly one Term_Lect.
- reset asserted during R_DIA after Seg/Min/Hora were captured: outputs stay 0, state IDLE, E_lect=0. A new lectura restarts at CMD.
